// File: rtl/add_sub_if.sv
// add_sub_if: operand/result bundle for add_sub_pipe.
//
// Handshake rule, for both the input and the output side: a transfer happens
// on a rising clk edge where valid && ready are both 1. A source holds its
// payload stable while valid && !ready. A sink may drive ready whether or not
// valid is asserted.
//
// Signals:
//   in_valid / in_ready  : operand handshake (producer -> block)
//   a, b                 : signed operands, WIDTH bits
//   sub                  : 0 = a+b, 1 = a-b
//   out_valid / out_ready: result handshake (block -> consumer)
//   out                  : signed result, WIDTH bits
//   overflow             : signed overflow of the unsaturated operation
//   carry_out            : carry out of the MSB (for subtract, 1 = no borrow)
//   zero                 : out == 0
//
// Modports:
//   master: the environment side (drives operands, accepts results)
//   slave : the add_sub_pipe side
interface add_sub_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             overflow;
    logic             carry_out;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, out, overflow, carry_out, zero
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, out, overflow, carry_out, zero
    );
endinterface

// File: rtl/add_sub_pipe.sv
// add_sub_pipe: pipelined two's-complement adder/subtractor.
//
// The WIDTH-bit carry chain is cut into STAGES segments of SEG bits. Stage k
// resolves bits [k*SEG +: SEG] in cycle k after acceptance, so the latency is
// STAGES cycles and the throughput is one result per cycle. The last stage
// also produces overflow / carry_out / zero and applies optional saturation.
//
// Parameters:
//   WIDTH  : operand/result width; must be a multiple of STAGES
//   STAGES : number of carry-chain segments (= latency in cycles)
//   SAT    : 1 clamps the result on signed overflow, 0 wraps
//
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; empties the pipeline and clears outputs
//   bus   : add_sub_if slave modport (operands in, result and flags out)
//
// Pipeline organisation:
//   Each stage k has a combinational segment adder fed by "stage inputs".
//   For stage 0 those are the bus operands. For stage k>0 they are the
//   registers written when stage k-1 advanced. Those registers hold only the
//   still-unresolved upper operand bits, the resolved low sum bits and the
//   segment carry. The last stage's results land in the output registers.
//   v_q[k] marks the register set written by stage k as occupied.
module add_sub_pipe #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4,
    parameter int SAT    = 0
) (
    input  logic       clk,
    input  logic       reset,
    add_sub_if.slave   bus
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // ------------------------------------------------------------------
    // Handshake / occupancy
    // ------------------------------------------------------------------
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] load;   // register set k may be written this cycle
    logic [STAGES-1:0] take;   // register set k is written with new data
    logic [STAGES-1:0] feed;   // valid arriving at stage k

    // A stage can load if the last stage retires, or if there is an empty
    // slot at or after it. In that case everything between shifts one step
    // forward, which collapses bubbles. Writing it as a downstream "hole"
    // scan keeps in_ready free of any dependency on in_valid.
    always_comb begin : handshake
        logic hole;
        hole = 1'b0;
        load = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            hole    = hole | ~v_q[k];
            load[k] = bus.out_ready | hole;
        end
        feed    = v_q << 1;
        feed[0] = bus.in_valid;
        take    = load & feed;
        v_d     = (load & feed) | (~load & v_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    assign bus.in_ready  = load[0];
    assign bus.out_valid = v_q[LAST];

    // ------------------------------------------------------------------
    // Carry-chain segments
    // ------------------------------------------------------------------
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits not yet consumed: [WIDTH-1 : k*SEG].
        localparam int HI_W = WIDTH - k * SEG;

        logic [HI_W-1:0]      a_hi;
        logic [HI_W-1:0]      bx_hi;     // b already inverted for subtract
        logic                 cin;
        logic [SEG:0]         seg_sum;   // segment sum plus carry out
        logic [(k+1)*SEG-1:0] res;       // all sum bits resolved so far

        assign seg_sum = {1'b0, a_hi[SEG-1:0]} + {1'b0, bx_hi[SEG-1:0]}
                       + {{SEG{1'b0}}, cin};

        if (k == 0) begin : g_in
            // Subtract is a + ~b + 1. The +1 enters as carry-in to segment 0.
            assign a_hi  = bus.a;
            assign bx_hi = bus.b ^ {WIDTH{bus.sub}};
            assign cin   = bus.sub;
            assign res   = seg_sum[SEG-1:0];
        end else begin : g_reg
            localparam int LO_W = k * SEG;

            logic [HI_W-1:0] a_q,  a_d;
            logic [HI_W-1:0] bx_q, bx_d;
            logic [LO_W-1:0] lo_q, lo_d;
            logic            c_q,  c_d;

            always_comb begin
                a_d  = a_q;
                bx_d = bx_q;
                lo_d = lo_q;
                c_d  = c_q;
                if (take[k-1]) begin
                    a_d  = g_stage[k-1].a_hi[HI_W+SEG-1:SEG];
                    bx_d = g_stage[k-1].bx_hi[HI_W+SEG-1:SEG];
                    lo_d = g_stage[k-1].res;
                    c_d  = g_stage[k-1].seg_sum[SEG];
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    a_q  <= '0;
                    bx_q <= '0;
                    lo_q <= '0;
                    c_q  <= 1'b0;
                end else begin
                    a_q  <= a_d;
                    bx_q <= bx_d;
                    lo_q <= lo_d;
                    c_q  <= c_d;
                end
            end

            assign a_hi  = a_q;
            assign bx_hi = bx_q;
            assign cin   = c_q;
            assign res   = {seg_sum[SEG-1:0], lo_q};
        end
    end

    // ------------------------------------------------------------------
    // Last stage: flags, saturation, output registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] out_q, out_d;
    logic             ovf_q, ovf_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] sum_w;
    logic             a_msb;
    logic             c_msb_in;
    logic             c_msb_out;

    always_comb begin
        sum_w     = g_stage[LAST].res;
        a_msb     = g_stage[LAST].a_hi[SEG-1];
        c_msb_out = g_stage[LAST].seg_sum[SEG];
        // The MSB sum bit is a ^ bx ^ carry_in, so the carry into the MSB
        // can be recovered from the sum without tapping the adder chain.
        c_msb_in  = sum_w[WIDTH-1] ^ a_msb ^ g_stage[LAST].bx_hi[SEG-1];

        out_d  = out_q;
        ovf_d  = ovf_q;
        cout_d = cout_q;
        zero_d = zero_q;
        if (take[LAST]) begin
            ovf_d  = c_msb_in ^ c_msb_out;
            cout_d = c_msb_out;
            out_d  = sum_w;
            // On signed overflow the true result lies beyond the range on
            // the side of a's sign, because both effective operands share it.
            if (SAT != 0 && ovf_d) begin
                out_d = a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                              : {1'b0, {(WIDTH-1){1'b1}}};
            end
            zero_d = (out_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q  <= '0;
            ovf_q  <= 1'b0;
            cout_q <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            ovf_q  <= ovf_d;
            cout_q <= cout_d;
            zero_q <= zero_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.overflow  = ovf_q;
    assign bus.carry_out = cout_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_add_sub_pipe.sv
// tb_add_sub_pipe: bench for add_sub_pipe (WIDTH=64, STAGES=4). The same
// stimulus drives one wrapping instance and one saturating instance.
module tb_add_sub_pipe;

    localparam int WIDTH  = 64;
    localparam int STAGES = 4;
    localparam int EXP_W  = WIDTH + 3;   // {out, overflow, carry_out, zero}

    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT wiring ----------------
    logic             in_valid  = 1'b0;
    logic             sub       = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;

    add_sub_if #(.WIDTH(WIDTH)) bus0 ();
    add_sub_if #(.WIDTH(WIDTH)) bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.a         = a;
    assign bus0.b         = b;
    assign bus0.sub       = sub;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.a         = a;
    assign bus1.b         = b;
    assign bus1.sub       = sub;
    assign bus1.out_ready = out_ready;

    add_sub_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .SAT(0)) dut_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    add_sub_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .SAT(1)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    // ---------------- checking helpers ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain arithmetic and sign rules.
    function automatic logic [EXP_W-1:0] model(input logic [63:0] x, input logic [63:0] y,
                                               input logic s, input bit sat);
        logic [63:0] r;
        logic [63:0] res;
        logic        ovf;
        logic        cout;
        if (s) begin
            r    = x - y;
            cout = (x >= y);                              // no borrow
            ovf  = (x[63] != y[63]) && (r[63] != x[63]);
        end else begin
            r    = x + y;
            cout = (r < x);                               // unsigned wrap
            ovf  = (x[63] == y[63]) && (r[63] != x[63]);
        end
        res = r;
        if (sat && ovf) res = x[63] ? MINN : MAXP;
        return {res, ovf, cout, (res == 64'd0)};
    endfunction

    function automatic logic [63:0] rand64();
        case ($urandom_range(0, 7))
            0:       return MAXP;
            1:       return MINN;
            2:       return ONES;
            3:       return 64'($urandom_range(0, 3));
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] exp0_q[$];
    logic [EXP_W-1:0] exp1_q[$];
    int               acc_cyc_q[$];
    int               ret_cyc_q[$];
    logic [EXP_W-1:0] e0;
    logic [EXP_W-1:0] e1;

    // Evaluated on the falling edge: inputs and outputs are stable there, and
    // the handshake seen now is the one the next rising edge will take.
    always @(negedge clk) begin
        if (reset) begin
            exp0_q.delete();
            exp1_q.delete();
        end else begin
            // Bubble-collapsing: room exists while fewer than STAGES are in
            // flight, or when the head retires this cycle.
            check("in_ready_occ0", 64'(bus0.in_ready),
                  64'((exp0_q.size() < STAGES) || out_ready));
            check("in_ready_occ1", 64'(bus1.in_ready),
                  64'((exp1_q.size() < STAGES) || out_ready));
            if (bus0.out_valid && out_ready) begin
                if (exp0_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_result0: got out=%h want no result", bus0.out);
                end else begin
                    e0 = exp0_q.pop_front();
                    check("sb_out0",  bus0.out,            e0[EXP_W-1:3]);
                    check("sb_ovf0",  64'(bus0.overflow),  64'(e0[2]));
                    check("sb_cout0", 64'(bus0.carry_out), 64'(e0[1]));
                    check("sb_zero0", 64'(bus0.zero),      64'(e0[0]));
                    ret_cyc_q.push_back(cyc);
                end
            end
            if (bus1.out_valid && out_ready) begin
                if (exp1_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_result1: got out=%h want no result", bus1.out);
                end else begin
                    e1 = exp1_q.pop_front();
                    check("sb_out1",  bus1.out,            e1[EXP_W-1:3]);
                    check("sb_ovf1",  64'(bus1.overflow),  64'(e1[2]));
                    check("sb_cout1", 64'(bus1.carry_out), 64'(e1[1]));
                    check("sb_zero1", 64'(bus1.zero),      64'(e1[0]));
                end
            end
            if (in_valid && bus0.in_ready) begin
                exp0_q.push_back(model(a, b, sub, 1'b0));
                acc_cyc_q.push_back(cyc);
            end
            if (in_valid && bus1.in_ready) exp1_q.push_back(model(a, b, sub, 1'b1));
        end
    end

    // ---------------- driver tasks ----------------
    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one transfer and returns just after the edge that accepts it.
    task automatic send(input logic [63:0] va, input logic [63:0] vb, input logic vs);
        int w;
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        sub      = vs;
        w        = 0;
        @(negedge clk);
        while (!bus0.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!bus0.in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready got 0 want 1");
        end
        step();
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp0_q.size() != 0 || exp1_q.size() != 0) && w < 100) begin
            step();
            w++;
        end
        total++;
        if (w >= 100) begin
            bad++;
            $display("FAIL drain_timeout: pending got %0d want 0", exp0_q.size());
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic [63:0] out0;
        logic        ovf;
        logic        cout;
        logic        zero0;
        logic [63:0] out1;
        logic        zero1;
    } vec_t;

    vec_t vecs[7];
    logic acc_last;
    int   lat;

    initial begin
        vecs[0] = '{MAXP, 64'd1, 1'b0, MINN, 1'b1, 1'b0, 1'b0, MAXP, 1'b0};
        vecs[1] = '{ONES, 64'd1, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 64'd0, 1'b1};
        vecs[2] = '{MINN, 64'd1, 1'b1, MAXP, 1'b1, 1'b1, 1'b0, MINN, 1'b0};
        vecs[3] = '{64'd5, 64'd5, 1'b1, 64'd0, 1'b0, 1'b1, 1'b1, 64'd0, 1'b1};
        vecs[4] = '{64'd0, 64'd1, 1'b1, ONES, 1'b0, 1'b0, 1'b0, ONES, 1'b0};
        vecs[5] = '{MINN, MINN, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1, MINN, 1'b0};
        vecs[6] = '{64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 64'h0000_0001_0000_0000,
                    1'b0, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0};

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid0", 64'(bus0.out_valid), 64'd0);
        check("rst_out_valid1", 64'(bus1.out_valid), 64'd0);
        check("rst_in_ready0",  64'(bus0.in_ready),  64'd1);
        check("rst_in_ready1",  64'(bus1.in_ready),  64'd1);
        check("rst_out0",       bus0.out,            64'd0);
        check("rst_out1",       bus1.out,            64'd0);
        check("rst_ovf",        64'(bus0.overflow),  64'd0);
        check("rst_cout",       64'(bus0.carry_out), 64'd0);
        check("rst_zero0",      64'(bus0.zero),      64'd0);
        check("rst_zero1",      64'(bus1.zero),      64'd0);
        step();
        out_ready = 1'b1;

        // ---- table: one transfer at a time, latency and values ----
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].sub);
            in_valid = 1'b0;
            lat = 0;
            @(negedge clk);
            while (!bus0.out_valid && lat < 20) begin
                lat++;
                @(negedge clk);
            end
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(STAGES - 1));
            check($sformatf("vec%0d_out0", i),  bus0.out,            vecs[i].out0);
            check($sformatf("vec%0d_ovf0", i),  64'(bus0.overflow),  64'(vecs[i].ovf));
            check($sformatf("vec%0d_cout0", i), 64'(bus0.carry_out), 64'(vecs[i].cout));
            check($sformatf("vec%0d_zero0", i), 64'(bus0.zero),      64'(vecs[i].zero0));
            check($sformatf("vec%0d_out1", i),  bus1.out,            vecs[i].out1);
            check($sformatf("vec%0d_ovf1", i),  64'(bus1.overflow),  64'(vecs[i].ovf));
            check($sformatf("vec%0d_zero1", i), 64'(bus1.zero),      64'(vecs[i].zero1));
            step();
        end
        drain();

        // ---- throughput: 16 back-to-back random transfers ----
        acc_cyc_q.delete();
        ret_cyc_q.delete();
        for (int i = 0; i < 16; i++) send(rand64(), rand64(), 1'($urandom_range(0, 1)));
        in_valid = 1'b0;
        drain();
        check("burst_accepts", 64'(acc_cyc_q.size()), 64'd16);
        check("burst_retires", 64'(ret_cyc_q.size()), 64'd16);
        if (acc_cyc_q.size() == 16 && ret_cyc_q.size() == 16) begin
            check("burst_accept_span", 64'(acc_cyc_q[15] - acc_cyc_q[0]), 64'd15);
            check("burst_first_lat",   64'(ret_cyc_q[0] - acc_cyc_q[0]),  64'(STAGES));
            check("burst_retire_span", 64'(ret_cyc_q[15] - ret_cyc_q[0]), 64'd15);
        end

        // ---- backpressure ----
        out_ready = 1'b0;
        for (int i = 0; i < STAGES; i++) send(rand64(), rand64(), 1'($urandom_range(0, 1)));
        a   = rand64();
        b   = rand64();
        sub = 1'($urandom_range(0, 1));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(bus0.in_ready),  64'd0);
            check("bp_valid",    64'(bus0.out_valid), 64'd1);
            if (exp0_q.size() != 0 && exp1_q.size() != 0) begin
                check("bp_hold_out0",  bus0.out,            exp0_q[0][EXP_W-1:3]);
                check("bp_hold_ovf0",  64'(bus0.overflow),  64'(exp0_q[0][2]));
                check("bp_hold_cout0", 64'(bus0.carry_out), 64'(exp0_q[0][1]));
                check("bp_hold_zero0", 64'(bus0.zero),      64'(exp0_q[0][0]));
                check("bp_hold_out1",  bus1.out,            exp1_q[0][EXP_W-1:3]);
            end
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 64'(bus0.in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        drain();

        // ---- reset with 3 transfers in flight ----
        for (int i = 0; i < 3; i++) send(rand64(), rand64(), 1'($urandom_range(0, 1)));
        reset    = 1'b1;
        in_valid = 1'b1;          // must be ignored on the reset edge
        a        = 64'd7;
        b        = 64'd9;
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", 64'(bus0.out_valid), 64'd0);
        check("mid_rst_in_ready",  64'(bus0.in_ready),  64'd1);
        check("mid_rst_out",       bus0.out,            64'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            @(negedge clk);
            check("mid_rst_quiet0", 64'(bus0.out_valid), 64'd0);
            check("mid_rst_quiet1", 64'(bus1.out_valid), 64'd0);
        end
        step();

        // ---- random traffic with random backpressure ----
        acc_last = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || acc_last) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a        = rand64();
                b        = rand64();
                sub      = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc_last = in_valid && bus0.in_ready;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/add_sub_pipe.md
# add_sub_pipe

Parametrised, pipelined two's-complement adder/subtractor for the execute-stage ALU datapath. It splits the WIDTH-bit carry chain into STAGES registered segments, with one segment resolved per cycle. It supports add and subtract per transaction and optional saturation. It reports signed overflow, carry-out and zero flags. Operands and results move through a valid/ready handshake, so the block can sit between stalling pipeline stages.

## Interface
- WIDTH, 64: operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4: number of carry-chain segments; this is also the latency in cycles. Legal values are 1..WIDTH, with WIDTH % STAGES == 0.
- SAT, 0: 1 clamps the result on signed overflow; 0 wraps.
- clk  input  1  rising-edge clock; the block's only clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  signed operand A.
- b  input  WIDTH  signed operand B.
- sub  input  1  0: a+b; 1: a-b.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out  output  WIDTH  signed result.
- overflow  output  1  signed overflow of the unsaturated operation.
- carry_out  output  1  carry out of the MSB; for subtraction, 1 means no borrow.
- zero  output  1  out == 0, evaluated after saturation.

## Operation
- Segment width SEG = WIDTH/STAGES. Stage k (0..STAGES-1) resolves bits [k*SEG +: SEG].
- Transfer at the input: a transfer occurs when in_valid && in_ready. At that edge, stage 0 captures:
  - sum bits of segment 0;
  - the segment carry;
  - a, and b XOR {WIDTH{sub}};
  - sub;
  - the carry into the MSB when STAGES==1.
- Carry-in to segment 0 equals sub.
- Stage k>0 adds its segment of the skewed operands plus the carry registered by stage k-1. It forwards the already-resolved low sum bits unchanged.
- The last stage performs all flag computation:
  - records the carry into the MSB and the carry out of the MSB;
  - overflow = c_in_msb XOR c_out_msb;
  - carry_out = c_out_msb.
- Saturation (SAT=1, overflow=1): out = 0111…1 when a[WIDTH-1]==0; out = 1000…0 otherwise.
- With SAT=0, out always holds the wrapped sum.
- zero reflects the final value of out.
- Each stage holds a valid bit. A stage loads when it is empty, or when its contents move forward in the same cycle. This makes the pipeline bubble-collapsing.
- Output side: the last stage drives out_valid. Its contents retire when out_valid && out_ready.
- in_ready = !v0 || (stage 0 advances this cycle).
  - in_ready is combinational from out_ready through the valid chain.
  - No combinational path exists from in_valid to in_ready.
- Result order equals acceptance order. No transaction is dropped or duplicated.

## Timing
- Reset (synchronous, clk edge with reset=1):
  - all stage valid bits clear;
  - out, overflow, carry_out and zero are 0;
  - out_valid is 0;
  - in_ready is 1 from the first cycle after reset.
- Reset mid-operation discards every in-flight transaction. in_valid/out_ready are ignored on the reset edge.
- Latency: a transfer accepted at edge N produces out_valid=1 after edge N+STAGES-1, with out_ready continuously high.
- Throughput: one result per cycle with out_ready held at 1.
- Backpressure: while out_valid && !out_ready, out and all flags hold stable. Upstream stages keep filling bubbles until they are all full; then in_ready=0.
- Full pipeline with out_ready=1 and in_valid=1: accept and retire happen in the same cycle, with no bubble inserted.
- Empty pipeline: out_valid=0; out and the flags hold their last retired values, which are don't-care to consumers.
- STAGES=1 degenerates to a single registered full-width add with the same handshake.

## Test plan
- Reset, then WIDTH=64, STAGES=4, SAT=0: a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> after 4 cycles out=0x8000_0000_0000_0000, overflow=1, carry_out=0, zero=0.
- Carry across every segment boundary: a=0xFFFF_FFFF_FFFF_FFFF, b=1, sub=0 -> out=0, carry_out=1, overflow=0, zero=1.
- Subtract with SAT=1: a=0x8000_0000_0000_0000, b=1, sub=1 -> out=0x8000_0000_0000_0000 (clamped), overflow=1. Also a=5, b=5, sub=1 -> out=0, zero=1, carry_out=1.
- Throughput and ordering: 16 back-to-back random transfers with out_ready=1 -> 16 results in order, one per cycle, first result 4 cycles after the first accept. Each result matches a golden model including flags.
- Backpressure: fill the pipeline, then drop out_ready for 6 cycles ->
  - out and flags stable throughout;
  - in_ready falls once all 4 stages are valid;
  - no loss or duplication after out_ready returns to 1.
- Reset mid-stream with 3 transactions in flight -> out_valid=0 on the next cycle, none of the 3 results ever appear, and in_ready=1.
